// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic {
        IDLE,
        REQ_PENDING
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at grant, filled at response, popped at head.
// Latency: a fill becomes visible at the head one cycle after it is written.
// Backpressure: the owner limits allocation by the used/pending counts; flush clears all entries.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_vld,
    input  logic [XLEN-1:0]    alloc_pc,
    input  logic               fill_vld,
    input  logic [INSTR_W-1:0] fill_dat,
    input  logic               pop,
    input  logic               flush,
    output logic               head_vld,
    output logic [XLEN-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [PW-1:0]      used,
    output logic [PW-1:0]      pending
);

    localparam int AW = PW - 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_entry_t;

    fetch_entry_t      entries [DEPTH];
    logic [PW-1:0]     tail_ptr;
    logic [PW-1:0]     fill_ptr;
    logic [PW-1:0]     head_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tail_ptr <= '0;
            fill_ptr <= '0;
            head_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            tail_ptr <= '0;
            fill_ptr <= '0;
            head_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
        end else begin
            if (alloc_vld) begin
                entries[tail_ptr[AW-1:0]].pc     <= alloc_pc;
                entries[tail_ptr[AW-1:0]].filled <= 1'b0;
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (fill_vld) begin
                entries[fill_ptr[AW-1:0]].instr  <= fill_dat;
                entries[fill_ptr[AW-1:0]].filled <= 1'b1;
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (pop) head_ptr <= head_ptr + PW'(1);
        end
    end

    // A popped slot keeps its stale filled bit until reallocated, so mask it when empty.
    assign head_vld   = entries[head_ptr[AW-1:0]].filled && (head_ptr != tail_ptr);
    assign head_pc    = entries[head_ptr[AW-1:0]].pc;
    assign head_instr = entries[head_ptr[AW-1:0]].instr;
    assign used       = tail_ptr - head_ptr;
    assign pending    = tail_ptr - fill_ptr;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: owns the fetch PC, issues req/gnt/rvalid accesses, queues words for decode.
// Latency: gnt in t, rvalid in t+k, out_valid in t+k+1 at the earliest; one request per cycle.
// Backpressure: out_ready low fills the queue; requests stop while queued plus dropping accesses reach DEPTH.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
);

    localparam int PW = $clog2(DEPTH) + 1;

    fetch_state_t       state, state_nxt;
    logic [XLEN-1:0]    fetch_pc, req_addr;
    logic               req_discard, discard_nxt;
    logic [PW-1:0]      drop_cnt, drop_nxt;
    logic [PW-1:0]      used, pending;
    logic [PW:0]        occupancy;
    logic               can_issue, pend_live, grant, grant_keep;
    logic               head_vld;
    logic [XLEN-1:0]    head_pc, last_pc;
    logic [INSTR_W-1:0] head_instr, last_instr;

    assign occupancy = {1'b0, used} + {1'b0, drop_cnt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pend_live   = (state == REQ_PENDING) && !req_discard;
        can_issue   = enable && !redirect_valid && (occupancy < (PW + 1)'(DEPTH));
        imem_req    = (state == REQ_PENDING) || can_issue;
        imem_addr   = (state == REQ_PENDING) ? req_addr : fetch_pc;
        grant       = imem_req && imem_gnt;
        // A grant for an access requested before a redirect belongs to the old stream.
        grant_keep  = grant && !redirect_valid && !((state == REQ_PENDING) && req_discard);
        if (imem_req && !imem_gnt) state_nxt = REQ_PENDING;
        else                       state_nxt = IDLE;
        discard_nxt = (state_nxt == REQ_PENDING) &&
                      (((state == REQ_PENDING) && req_discard) || redirect_valid);
        drop_nxt    = drop_cnt;
        if (redirect_valid)
            drop_nxt = drop_cnt + pending + PW'(pend_live) - PW'(imem_rvalid);
        else if (imem_rvalid && (drop_cnt != '0))
            drop_nxt = drop_cnt - PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_VECTOR;
            req_addr    <= RESET_VECTOR;
            req_discard <= 1'b0;
            drop_cnt    <= '0;
            last_pc     <= '0;
            last_instr  <= '0;
        end else begin
            req_discard <= discard_nxt;
            drop_cnt    <= drop_nxt;
            if ((state == IDLE) && imem_req && !imem_gnt) req_addr <= fetch_pc;
            if (redirect_valid)  fetch_pc <= redirect_pc & ~XLEN'(3);
            else if (grant_keep) fetch_pc <= fetch_pc + XLEN'(4);
            if (head_vld) begin
                last_pc    <= head_pc;
                last_instr <= head_instr;
            end
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .alloc_vld  (grant_keep),
        .alloc_pc   (imem_addr),
        .fill_vld   (imem_rvalid && (drop_cnt == '0) && !redirect_valid),
        .fill_dat   (imem_rdata),
        .pop        (head_vld && out_ready),
        .flush      (redirect_valid),
        .head_vld   (head_vld),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .used       (used),
        .pending    (pending)
    );

    assign out_valid = head_vld;
    assign out_pc    = head_vld ? head_pc    : last_pc;
    assign out_instr = head_vld ? head_instr : last_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model returns ~addr as data, expected grants/outputs queued by stimulus.
module tb_fetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, enable, imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
    logic        redirect_valid, out_valid, out_ready;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    typedef struct { logic [31:0] addr; int due; } mem_rsp_t;
    mem_rsp_t    mq[$];
    logic [31:0] exp_gnt[$];
    logic [31:0] exp_out[$];
    logic [31:0] mon_e, mon_ei;
    int n_tests = 0, n_fail = 0, n_gnt = 0, cyc = 0;
    int mem_lat = 1, t_gnt = -1, t_vld = -1;
    bit rsp_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks grants and decoder-side pops against the expected queues.
    always @(negedge clk) begin
        if (reset) begin
            if (imem_req && imem_gnt) begin
                n_gnt++;
                if (t_gnt < 0) t_gnt = cyc;
                mq.push_back('{imem_addr, cyc + mem_lat});
                if (exp_gnt.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL gnt_unexpected: got addr 0x%0h, expected no grant", imem_addr);
                end else check("gnt_addr", imem_addr, exp_gnt.pop_front());
            end
            if (out_valid && t_vld < 0) t_vld = cyc;
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL out_unexpected: got pc 0x%0h, expected no output", out_pc);
                end else begin
                    mon_e  = exp_out.pop_front();
                    mon_ei = ~mon_e;
                    check("out_pc", out_pc, mon_e);
                    check("out_instr", out_instr, mon_ei);
                end
            end
        end
    end

    // Instruction memory: in-order responses mem_lat cycles after grant, data = ~addr.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (!reset) mq.delete();
            else if (rsp_en && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~mq[0].addr;
                void'(mq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; enable = 1'b0; imem_gnt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0; rsp_en = 1'b1; mem_lat = 1;
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic issue(input string name, input int n);
        int target;
        target = n_gnt + n;
        enable = 1'b1;
        for (int k = 0; k < 200 && n_gnt < target; k++) step();
        enable = 1'b0;
        check({name, "_gnt_cnt"}, n_gnt, target);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 300 && (exp_out.size() != 0 || mq.size() != 0); k++) step();
        repeat (3) step();
        check({name, "_drained"}, exp_out.size() + exp_gnt.size(), 0);
        @(negedge clk);
        check({name, "_empty"}, out_valid, 1'b0);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] tmp;
        reset = 1'b0; enable = 1'b0; imem_gnt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        apply_reset();

        // T1: streaming at one request per cycle
        out_ready = 1'b1; imem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_gnt.push_back(32'(i * 4));
            exp_out.push_back(32'(i * 4));
        end
        issue("t1", 8);
        drain("t1");
        check("t1_latency", t_vld - t_gnt, 2);
        check("t1_hold_pc", out_pc, 32'h1C);
        tmp = ~32'h1C;
        check("t1_hold_instr", out_instr, tmp);

        // T2: decoder stalled, credit limit at DEPTH
        apply_reset();
        imem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_gnt.push_back(32'(i * 4));
            exp_out.push_back(32'(i * 4));
        end
        tmp = n_gnt;
        enable = 1'b1;
        repeat (8) step();
        check("t2_full_gnts", n_gnt - tmp, 4);
        @(negedge clk);
        check("t2_full_req", imem_req, 1'b0);
        step(); out_ready = 1'b1;
        step(); out_ready = 1'b0;
        repeat (4) step();
        check("t2_refill_gnts", n_gnt - tmp, 5);
        enable = 1'b0; out_ready = 1'b1;
        drain("t2");

        // T3: redirect flushes queued words and drops two in-flight responses
        apply_reset();
        imem_gnt = 1'b1;
        exp_gnt.push_back(32'h0);   exp_gnt.push_back(32'h4);
        exp_gnt.push_back(32'h8);   exp_gnt.push_back(32'hC);
        exp_gnt.push_back(32'h100); exp_gnt.push_back(32'h104);
        exp_out.push_back(32'h100); exp_out.push_back(32'h104);
        issue("t3a", 2);
        repeat (3) step();
        @(negedge clk);
        check("t3_queued", out_valid, 1'b1);
        step(); rsp_en = 1'b0;
        issue("t3b", 2);
        redirect_to(32'h103);
        @(negedge clk);
        check("t3_flushed", out_valid, 1'b0);
        step(); out_ready = 1'b1; rsp_en = 1'b1;
        issue("t3c", 2);
        drain("t3");

        // T4: pending request held through a redirect, then discarded
        apply_reset();
        out_ready = 1'b1;
        exp_gnt.push_back(32'h0); exp_gnt.push_back(32'h40); exp_gnt.push_back(32'h44);
        exp_out.push_back(32'h40); exp_out.push_back(32'h44);
        step(); enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold", {imem_req, imem_addr}, {1'b1, 32'h0});
        end
        step(); enable = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        check("t4_hold_redir", {imem_req, imem_addr}, {1'b1, 32'h0});
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_hold_after", {imem_req, imem_addr}, {1'b1, 32'h0});
        step(); imem_gnt = 1'b1;
        issue("t4", 3);
        drain("t4");

        // T5: PC wraps modulo 2^XLEN
        exp_gnt.push_back(32'hFFFF_FFFC); exp_gnt.push_back(32'h0); exp_gnt.push_back(32'h4);
        exp_out.push_back(32'hFFFF_FFFC); exp_out.push_back(32'h0); exp_out.push_back(32'h4);
        redirect_to(32'hFFFF_FFFC);
        issue("t5", 3);
        drain("t5");

        // T6: asynchronous reset with entries queued
        out_ready = 1'b0;
        exp_gnt.push_back(32'h8); exp_gnt.push_back(32'hC); exp_gnt.push_back(32'h10);
        issue("t6", 3);
        repeat (3) step();
        @(negedge clk);
        check("t6_queued", out_valid, 1'b1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("t6_rst_req", imem_req, 1'b0);
        check("t6_rst_addr", imem_addr, 32'h0);
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_pc", out_pc, 32'h0);
        check("t6_rst_instr", out_instr, 32'h0);
        repeat (2) step();
        reset = 1'b1; out_ready = 1'b1; imem_gnt = 1'b1;
        exp_gnt.push_back(32'h0); exp_gnt.push_back(32'h4);
        exp_out.push_back(32'h0); exp_out.push_back(32'h4);
        issue("t6r", 2);
        drain("t6r");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation core. It replaces the combinational PC-to-instruction-memory path with a decoupled fetch stage.
- Owns the fetch PC and issues requests to an instruction memory over a req/gnt/rvalid handshake that tolerates latency.
- Buffers returned instructions with their PCs in an in-order queue and presents them to the decoder over valid/ready.
- Supports a redirect (jump/branch) that flushes everything in flight.

Parameters:
XLEN, 32, address/PC width in bits
DEPTH, 4, queue entries and maximum accesses in flight; power of two, >=2
RESET_VECTOR, 0, fetch PC after reset; bits [1:0] must be 0

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
enable  input  1  permits issuing new fetch requests
imem_req  output  1  fetch request
imem_addr  output  XLEN  word-aligned fetch address
imem_gnt  input  1  request accepted this cycle (valid only while imem_req=1)
imem_rvalid  input  1  in-order read response valid
imem_rdata  input  32  instruction word
redirect_valid  input  1  redirect fetch stream (taken jump/branch)
redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored and forced to 0
out_valid  output  1  instruction available to decoder
out_ready  input  1  decoder accepts instruction
out_instr  output  32  instruction word
out_pc  output  XLEN  address of out_instr

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_VECTOR; queue empty; in-flight=0; drop_cnt=0.
  - imem_req=0, imem_addr=RESET_VECTOR, out_valid=0, out_instr=0, out_pc=0.
  - Instruction memory shares this reset; pre-reset responses are never expected.
- Credit: occupancy = queue entries allocated (filled or awaiting data). A request is raised only when enable=1, occupancy<DEPTH and no redirect is in this cycle.
- Request hold: once imem_req=1, imem_req and imem_addr stay stable until imem_gnt=1, even if enable drops or a redirect arrives.
  - If a redirect arrives while a request is pending, that access is tagged for discard when granted.
- Grant:
  - Allocate the tail entry with pc=imem_addr, filled=0.
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^XLEN.
  - A new request may be issued in the next cycle. Throughput is one request per cycle when gnt is held at 1.
- Response: imem_rvalid fills the oldest unfilled entry (fill pointer) with imem_rdata. Responses arrive in order, at most one per cycle.
- Output: out_valid = head entry filled (registered state only; no combinational path from any input). A pop occurs on out_valid & out_ready.
  - Minimum latency: gnt in cycle t, rvalid in t+k, out_valid in t+k+1.
- Redirect (redirect_valid=1, cycle t):
  - All queue entries are discarded; out_valid=0 from t+1.
  - drop_cnt <= number of granted-but-unreturned accesses, plus 1 if an ungranted request is pending.
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - First new request issues no earlier than t+1, and only after any pending old request has been granted.
- Drop: while drop_cnt>0, each imem_rvalid decrements drop_cnt and writes nothing.
  - New-stream grants may proceed during the drop; the credit check counts dropping accesses as occupancy.
- Simultaneous events:
  - redirect + rvalid in the same cycle: the response belongs to the old stream and is dropped.
  - redirect + pop: flush wins.
  - gnt + rvalid + pop in the same cycle: all three are applied. Occupancy change = +1 (gnt) -1 (pop).
- Full: occupancy=DEPTH gives imem_req=0, except for an already pending request, which cannot exist because of the credit check.
- Empty: out_valid=0; out_instr/out_pc hold their last values.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.

Decomposition:
- TypesPkg gains fetch_entry_t (struct: logic [XLEN-1:0] pc; logic [31:0] instr; logic filled).
- One sub-module, fetch_queue: DEPTH-entry circular buffer with alloc/fill/pop/flush ports and separate tail, fill and head pointers.
- fetch_unit holds fetch_pc, the request FSM (IDLE, REQ_PENDING) and drop_cnt.

Test Plan:
1. Reset release, enable=1, gnt=1 always, rvalid 1 cycle after gnt, out_ready=1 -> imem_addr 0x0,0x4,0x8,... one per cycle; out_pc/out_instr match in order; first out_valid 2 cycles after first gnt.
2. out_ready=0, DEPTH=4 -> exactly 4 grants (0x0..0xC), then imem_req=0; out_ready=1 for 1 cycle -> one pop, one new request at 0x10.
3. Two accesses in flight (0x8, 0xC), redirect_pc=0x103 -> fetch_pc=0x100; the next two rvalids are dropped; first out_pc=0x100 with its own data.
4. imem_req pending with gnt held 0 for 3 cycles, redirect to 0x40 -> imem_addr stays at the old value until gnt; that response is dropped; next request is 0x40.
5. Redirect to 0xFFFFFFFC (XLEN=32) -> fetch PCs 0xFFFFFFFC, 0x00000000 (wrap).
6. reset asserted mid-stream with 3 entries queued -> outputs return to reset values immediately (asynchronous); after release, fetch restarts at RESET_VECTOR.
